// File: rtl/mod107_pkg.sv
// mod107_pkg: shared constants, FSM states and the single-step mod-107 reduction
package mod107_pkg;
  localparam int MOD = 107;
  localparam int RES_W = 7;
  localparam int NCHUNK = 67;
  localparam int CNT_W = 7;
  typedef enum logic {ACC, DONE} state_t;
  function automatic logic [RES_W-1:0] red107(input logic [7:0] x);
    logic [7:0] t;
    t = x >= 8'(MOD) ? x - 8'(MOD) : x;
    return t[RES_W-1:0];
  endfunction
endpackage

// File: rtl/mod107_add.sv
// mod107_add: (a + pre-reduced b) mod 107 with an out-of-range flag on b
module mod107_add import mod107_pkg::*; (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum,
  output logic             oor
);
  logic [RES_W-1:0] r;
  always_comb begin
    oor = b >= RES_W'(MOD);
    r = red107({1'b0, b});
    sum = red107({1'b0, a} + {1'b0, r});
  end
endmodule

// File: rtl/mod107_residue_accumulator.sv
// mod107_residue_accumulator: sums per-chunk residues mod 107 over a frame, result via valid/ready
module mod107_residue_accumulator import mod107_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_residue,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_residue,
  output logic             out_err
);
  state_t state, state_nx;
  logic [RES_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt;
  logic err, oor, take, last_cnt, fin, err_nx;
  mod107_add u_add (.a(acc), .b(in_residue), .sum(sum), .oor(oor));
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  always_comb begin
    take = in_valid & in_ready;
    last_cnt = cnt == CNT_W'(NCHUNK - 1);
    fin = in_last | last_cnt;
    // in_last and the final count must coincide; either one alone is a framing error
    err_nx = err | oor | (in_last ^ last_cnt);
    state_nx = state;
    state_nx = state == ACC ? ((take && fin) ? DONE : ACC) : (out_ready ? ACC : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
      out_residue <= '0;
      out_err <= 1'b0;
    end else if (take) begin
      acc <= fin ? '0 : sum;
      cnt <= fin ? '0 : cnt + 1'b1;
      err <= fin ? 1'b0 : err_nx;
      if (fin) begin
        out_residue <= sum;
        out_err <= err_nx;
      end
    end
endmodule
